usb_fs_rx_frontend: RTL and testbench

Full-speed USB receive front end in the PHY clock domain: synchronises the raw D+/D- pads, recovers bit timing from the 4x-oversampled line, NRZI-decodes, strips stuff bits, detects SYNC and EOP, and delivers packet bytes to the device core's packet decoder. It sits between the `uio_in[1:0]` pad reads and the UsbDeviceTop receive path, clocked by the divided 48 MHz `phyCd_clk`.

---
 rtl/usb_fs_rx_frontend.sv | 184 ++++++++++++++++++
 tb/tb_usb_fs_rx_frontend.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_rx_frontend.sv
// usb_fs_rx_frontend: full-speed USB receive front end (sync, DPLL, NRZI, destuff, SYNC/EOP, bytes)
//   Optional USB_RX_GLITCH_FILTER_EN: 3-tap majority filter per pad after the synchroniser.
//   phyCd_clk/phyCd_reset : PHY clock, synchronous active-high reset
//   usb_dp_read/dm_read   : raw asynchronous pads
//   rx_enable             : receiver enabled (low while transmitting)
//   line_state            : synchronised line {dm,dp}: 00 SE0, 01 J, 10 K, 11 SE1
//   rx_active             : inside a packet (SYNC accepted until EOP/abort)
//   rx_data/rx_valid      : last completed byte (LSB first) and its one-cycle strobe
//   rx_eop/rx_error       : clean end-of-packet strobe, error strobe
module usb_fs_rx_frontend #(
    parameter int OVERSAMPLE     = 4,
    parameter int SYNC_MIN_ZEROS = 3
) (
    input  logic       phyCd_clk,
    input  logic       phyCd_reset,
    input  logic       usb_dp_read,
    input  logic       usb_dm_read,
    input  logic       rx_enable,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_error
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [1:0] LS_SE0 = 2'b00, LS_J = 2'b01, LS_K = 2'b10, LS_SE1 = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ABORT} state_t;
    logic dp_s1_q, dp_s2_q, dm_s1_q, dm_s2_q;
    logic [1:0] prev_line_q;
    logic [PW-1:0] phase_q, phase_d;
    logic changed, strobe, is_j, is_k, nrzi_bit;
    state_t state_q, state_d;
    logic prev_k_q, prev_k_d;
    logic [3:0] zeros_q, zeros_d;
    logic [2:0] ones_q, ones_d, bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, data_q, data_d, byte_d;
    logic valid_q, valid_d, eop_q, eop_d, err_q, err_d, active_q, active_d;

    // Synchronisers reset to J so reset never looks like SE0.
    always_ff @(posedge phyCd_clk) begin
        if (phyCd_reset) begin
            {dp_s1_q, dp_s2_q} <= 2'b11;
            {dm_s1_q, dm_s2_q} <= 2'b00;
        end else begin
            {dp_s1_q, dp_s2_q} <= {usb_dp_read, dp_s1_q};
            {dm_s1_q, dm_s2_q} <= {usb_dm_read, dm_s1_q};
        end
    end

`ifdef USB_RX_GLITCH_FILTER_EN
    logic dp_h1_q, dp_h2_q, dm_h1_q, dm_h2_q;
    always_ff @(posedge phyCd_clk) begin
        if (phyCd_reset) begin
            {dp_h1_q, dp_h2_q} <= 2'b11;
            {dm_h1_q, dm_h2_q} <= 2'b00;
        end else begin
            {dp_h1_q, dp_h2_q} <= {dp_s2_q, dp_h1_q};
            {dm_h1_q, dm_h2_q} <= {dm_s2_q, dm_h1_q};
        end
    end
    // Majority over three consecutive samples: a one-cycle pulse never wins.
    assign line_state = {(dm_s2_q & dm_h1_q) | (dm_s2_q & dm_h2_q) | (dm_h1_q & dm_h2_q),
                         (dp_s2_q & dp_h1_q) | (dp_s2_q & dp_h2_q) | (dp_h1_q & dp_h2_q)};
`else
    assign line_state = {dm_s2_q, dp_s2_q};
`endif

    // DPLL: phase is 0 in the cycle a transition is seen, strobe mid-bit.
    assign changed  = line_state != prev_line_q;
    assign phase_d  = changed ? '0 : (phase_q == PW'(OVERSAMPLE - 1) ? '0 : phase_q + 1'b1);
    assign strobe   = phase_d == PW'(OVERSAMPLE / 2);
    assign is_j     = line_state == LS_J;
    assign is_k     = line_state == LS_K;
    assign nrzi_bit = is_k == prev_k_q;
    assign byte_d   = {nrzi_bit, shift_q[7:1]};

    always_comb begin
        state_d   = state_q;
        prev_k_d  = prev_k_q;
        zeros_d   = zeros_q;
        ones_d    = ones_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        eop_d     = 1'b0;
        err_d     = 1'b0;
        if (!rx_enable) begin
            state_d = S_IDLE;
        end else if (strobe) begin
            case (state_q)
                S_IDLE: if (is_k) begin
                    state_d  = S_SYNC;
                    prev_k_d = 1'b1;
                    zeros_d  = '0;
                end
                S_SYNC: if (!is_j && !is_k) begin
                    state_d = S_IDLE;
                end else begin
                    prev_k_d = is_k;
                    if (!nrzi_bit) zeros_d = zeros_q + 4'(zeros_q != 4'hf);
                    else if (zeros_q >= 4'(SYNC_MIN_ZEROS)) begin
                        state_d   = S_DATA;
                        ones_d    = '0;
                        bit_cnt_d = '0;
                    end else state_d = S_IDLE;
                end
                S_DATA: if (line_state == LS_SE0) begin
                    state_d = S_EOP;
                end else if (line_state == LS_SE1) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    prev_k_d = is_k;
                    // After six ones the next bit is a stuff bit, never data.
                    if (ones_q == 3'd6) begin
                        if (nrzi_bit) begin
                            err_d   = 1'b1;
                            state_d = S_ABORT;
                        end else ones_d = '0;
                    end else begin
                        ones_d    = nrzi_bit ? ones_q + 1'b1 : '0;
                        shift_d   = byte_d;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = byte_d;
                            valid_d = 1'b1;
                        end
                    end
                end
                S_EOP: if (is_j) begin
                    eop_d   = 1'b1;
                    err_d   = bit_cnt_q != 3'd0;
                    state_d = S_IDLE;
                end else if (line_state != LS_SE0) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end
                S_ABORT: if (is_j) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        active_d = state_d == S_DATA || state_d == S_EOP;
    end

    always_ff @(posedge phyCd_clk) begin
        if (phyCd_reset) begin
            prev_line_q <= LS_J;
            phase_q     <= '0;
            state_q     <= S_IDLE;
            prev_k_q    <= 1'b0;
            zeros_q     <= '0;
            ones_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            prev_line_q <= line_state;
            phase_q     <= phase_d;
            state_q     <= state_d;
            prev_k_q    <= prev_k_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
            active_q    <= active_d;
        end
    end

    assign rx_active = active_q;
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_eop    = eop_q;
    assign rx_error  = err_q;
endmodule

// File: tb/tb_usb_fs_rx_frontend.sv
// tb_usb_fs_rx_frontend: table-driven packets with an event scoreboard for usb_fs_rx_frontend
module tb_usb_fs_rx_frontend;
    localparam logic [1:0] J = 2'b01, K = 2'b10, SE0 = 2'b00;
    logic clk = 1'b0, rst = 1'b1, dp = 1'b1, dm = 1'b0, en = 1'b1;
    logic [1:0] ls;
    logic act, valid, eop, err;
    logic [7:0] data;
    int tests = 0, fails = 0;

    typedef struct packed {logic v; logic e; logic r; logic [7:0] d;} ev_t;
    typedef struct {logic [15:0] bytes; int n; int extra; bit jit; int glitch; logic [7:0] last;} vec_t;
    ev_t exp_q[$];
    ev_t got_ev, exp_ev;
    vec_t vecs[8];
    int nvec;
    logic [1:0] lvl = J;
    int ones = 0, dbit = 0, glitch_at = -1;
    bit jit = 1'b0, phase5 = 1'b0;

    always #5 clk = ~clk;

    usb_fs_rx_frontend dut (
        .phyCd_clk(clk), .phyCd_reset(rst), .usb_dp_read(dp), .usb_dm_read(dm),
        .rx_enable(en), .line_state(ls), .rx_active(act), .rx_data(data),
        .rx_valid(valid), .rx_eop(eop), .rx_error(err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic push(input logic v, input logic e, input logic r, input logic [7:0] d);
        exp_q.push_back({v, e, r, d});
    endtask

    task automatic hold(input logic [1:0] l, input int n);
        {dm, dp} = l;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_len(output int n);
        if (jit) begin
            n = phase5 ? 5 : 3;
            phase5 = !phase5;
        end else n = 4;
    endtask

    task automatic raw_bit(input bit b, input bit g);
        int n;
        if (!b) lvl = (lvl == J) ? K : J;
        bit_len(n);
        if (g) begin
            hold(lvl, 1);
            hold(SE0, 1);
            hold(lvl, n - 2);
        end else hold(lvl, n);
    endtask

    task automatic data_bit(input bit b);
        raw_bit(b, dbit == glitch_at);
        dbit++;
        if (b) begin
            ones++;
            if (ones == 6) begin
                raw_bit(1'b0, 1'b0);
                ones = 0;
            end
        end else ones = 0;
    endtask

    task automatic send_sync;
        lvl = J;
        dbit = 0;
        ones = 0;
        for (int i = 0; i < 7; i++) raw_bit(1'b0, 1'b0);
        raw_bit(1'b1, 1'b0);
    endtask

    task automatic send_eop;
        int n1, n2, n3;
        bit_len(n1);
        bit_len(n2);
        hold(SE0, n1 + n2);
        lvl = J;
        bit_len(n3);
        hold(J, n3);
        hold(J, 16);
    endtask

    task automatic send_vec(input vec_t v);
        jit = v.jit;
        phase5 = 1'b0;
        glitch_at = v.glitch;
        send_sync;
        for (int i = 0; i < v.n; i++) begin
            push(1'b1, 1'b0, 1'b0, v.bytes[8*i +: 8]);
            for (int k = 0; k < 8; k++) data_bit(v.bytes[8*i + k]);
        end
        for (int i = 0; i < v.extra; i++) data_bit(1'b0);
        push(1'b0, 1'b1, v.extra != 0, 8'h00);
        send_eop;
        jit = 1'b0;
        glitch_at = -1;
    endtask

    // Scoreboard: every strobe cycle must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (valid || eop || err)) begin
            got_ev = {valid, eop, err, valid ? data : 8'h00};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event got=%0h required=none", got_ev);
            end else begin
                exp_ev = exp_q.pop_front();
                if (got_ev !== exp_ev) begin
                    fails++;
                    $display("FAIL event got=%0h required=%0h", got_ev, exp_ev);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{16'h00A5, 1, 0, 1'b0, -1, 8'hA5};
        vecs[1] = '{16'h3FFF, 2, 0, 1'b0, -1, 8'h3F};
        vecs[2] = '{16'h00FC, 1, 0, 1'b0, -1, 8'hFC};
        vecs[3] = '{16'hC35A, 2, 0, 1'b1, -1, 8'hC3};
        vecs[4] = '{16'h00A5, 1, 3, 1'b0, -1, 8'hA5};
        vecs[5] = '{16'hFF00, 2, 0, 1'b0, -1, 8'hFF};
        nvec = 6;
`ifdef USB_RX_GLITCH_FILTER_EN
        vecs[nvec] = '{16'hC35A, 2, 0, 1'b0, 3, 8'hC3};
        nvec++;
`endif
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("reset_idle", {ls, act, valid, eop, err, data}, {J, 4'b0000, 8'h00});
        end
        for (int i = 0; i < nvec; i++) begin
            send_vec(vecs[i]);
            check("idle_after_pkt", act, 0);
            check("data_hold", data, vecs[i].last);
        end
        push(1'b0, 1'b0, 1'b1, 8'h00);
        send_sync;
        raw_bit(1'b1, 1'b0);
        raw_bit(1'b1, 1'b0);
        check("active_in_data", act, 1);
        repeat (5) raw_bit(1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("abort_active", act, 0);
        check("abort_data_kept", data, vecs[nvec-1].last);
        hold(J, 24);
        send_vec(vecs[0]);
        check("recover_data", data, 8'hA5);
        send_sync;
        data_bit(1'b1);
        data_bit(1'b0);
        data_bit(1'b1);
        data_bit(1'b0);
        check("active_before_disable", act, 1);
        en = 1'b0;
        @(negedge clk);
        check("disable_active", act, 0);
        for (int i = 0; i < 4; i++) data_bit(1'b1);
        send_eop;
        check("disabled_line_j", ls, J);
        check("disabled_data_kept", data, 8'hA5);
        en = 1'b1;
        hold(J, 16);
        send_vec(vecs[1]);
        check("reenable_data", data, 8'h3F);
        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
